ra_stack_ctrl: RTL

RA_STACK_CTRL -- requirements
Module: ra_stack_ctrl

---
 rtl/ra_stack_ctrl_pkg.sv | 20 ++
 rtl/ra_mem.sv | 25 ++
 rtl/ra_stack_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/ra_stack_ctrl_pkg.sv
// Shared CPU definitions for the return-address stack: default sizes and the
// push/pop operation encoding.
package ra_stack_ctrl_pkg;

  localparam int unsigned RaDefaultAw    = 10;
  localparam int unsigned RaDefaultDepth = 8;

  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpPush = 2'b01,
    OpPop  = 2'b10,
    OpRepl = 2'b11
  } ra_op_e;

  // Encoding is {pop, push}, so the strobes map straight onto the enum.
  function automatic ra_op_e ra_op_decode(input logic push, input logic pop);
    return ra_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/ra_mem.sv
// Return-address entry array: one synchronous write port, one asynchronous
// read port.
module ra_mem #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [Width-1:0]         wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ra_stack_ctrl.sv
// Return-address stack controller: stack pointer, sticky error flags and a
// zero-latency top-of-stack output for the PC mux.
module ra_stack_ctrl
  import ra_stack_ctrl_pkg::*;
#(
  parameter int unsigned AW    = RaDefaultAw,
  parameter int unsigned DEPTH = RaDefaultDepth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_subrutina,
  input  logic                   s_ra,
  input  logic [AW-1:0]          pc_ret,
  input  logic                   clr_err,
  output logic [AW-1:0]          ra_out,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf,
  output logic                   unf
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned SpW  = IdxW + 1;

  logic [SpW-1:0]  sp_q, sp_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            is_full, is_empty;
  logic            mem_we;
  logic [IdxW-1:0] waddr, top_idx;
  logic [AW-1:0]   top_data;
  ra_op_e          op;

  assign op       = ra_op_decode(s_subrutina, s_ra);
  assign is_full  = (sp_q == SpW'(DEPTH));
  assign is_empty = (sp_q == '0);
  assign top_idx  = IdxW'(sp_q - SpW'(1));

  always_comb begin
    sp_d   = sp_q;
    ovf_d  = ovf_q & ~clr_err;
    unf_d  = unf_q & ~clr_err;
    mem_we = 1'b0;
    waddr  = IdxW'(sp_q);

    unique case (op)
      OpNone: begin
      end
      OpPush: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          mem_we = 1'b1;
          sp_d   = sp_q + SpW'(1);
        end
      end
      OpPop: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          sp_d = sp_q - SpW'(1);
        end
      end
      OpRepl: begin
        mem_we = 1'b1;
        if (is_empty) begin
          // Nothing to return to: degrade to a plain push, but flag it.
          sp_d  = SpW'(1);
          unf_d = 1'b1;
        end else begin
          waddr = top_idx;
        end
      end
    endcase

    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ra_mem #(
    .Width (AW),
    .Depth (DEPTH)
  ) u_ra_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (waddr),
    .wdata (pc_ret),
    .raddr (top_idx),
    .rdata (top_data)
  );

  assign ra_out = is_empty ? '0 : top_data;
  assign depth  = sp_q;
  assign full   = is_full;
  assign empty  = is_empty;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

endmodule
